// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter: FSM state encoding,
// frame geometry and the even-parity function.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 11;

  function automatic logic uart_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CYCLES_PER_BIT-1 and flags the last cycle of
// each period. clear_i holds the count at zero so every state entry starts fresh.
module uart_baud_gen #(
  parameter int CYCLES_PER_BIT = 4
) (
  input  logic clk,
  input  logic nRst,
  input  logic clear_i,
  output logic bit_end_o
);

  localparam int CW = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_end_o = (cnt_q == CW'(CYCLES_PER_BIT - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || bit_end_o) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start, 8 data bits LSB-first, even parity, stop.
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry byte FIFO ahead of the FSM.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int BAUD_RATE      = 9600,
  parameter int CLOCK_FREQ     = 50000000,
  parameter int CYCLES_PER_BIT = CLOCK_FREQ / BAUD_RATE,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       enable,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  if (CYCLES_PER_BIT < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("uart_transmitter: CYCLES_PER_BIT must be >= 1 and FIFO_DEPTH a power of 2 >= 2");
  end

  uart_tx_state_t state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] idx_q, idx_d;
  logic       par_q, par_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       bit_end;
  logic       load;
  logic [7:0] load_byte;

  uart_baud_gen #(.CYCLES_PER_BIT(CYCLES_PER_BIT)) u_baud (
    .clk      (clk),
    .nRst     (nRst),
    .clear_i  (state_q == IDLE),
    .bit_end_o(bit_end)
  );

`ifdef UART_TX_FIFO_EN
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [7:0]    fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   count_q;
  logic          push, pop;

  assign data_ready = nRst & enable & (count_q != (PW+1)'(FIFO_DEPTH));
  assign push       = data_valid & data_ready;
  assign pop        = enable & (state_q == IDLE) & (count_q != '0);
  assign load       = pop;
  assign load_byte  = fifo_mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wptr_q] <= data_in;
  end

  // Pointers wrap naturally since FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (!enable) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end
`else
  // nRst gates ready so the handshake drops the moment reset asserts.
  assign data_ready = nRst & enable & (state_q == IDLE);
  assign load       = data_valid & data_ready;
  assign load_byte  = data_in;
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    par_d   = par_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      tx_d    = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          tx_d = 1'b1;
          if (load) begin
            shift_d = load_byte;
            par_d   = uart_parity(load_byte);
            idx_d   = '0;
            state_d = START;
            tx_d    = 1'b0;
          end
        end
        START: if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
        DATA: if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == 3'(UART_DATA_BITS - 1)) begin
            state_d = PARITY;
            tx_d    = par_q;
          end else begin
            idx_d = idx_q + 1'b1;
            tx_d  = shift_q[1];
          end
        end
        PARITY: if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
        STOP: if (bit_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
        default: begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter (default build, CYCLES_PER_BIT=4): a frame-level
// line model checked every cycle, plus hand-derived frame captures.
module tb_uart_transmitter;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       nRst;
  logic       enable;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       tx;
  logic       busy;
  logic       tx_done;

  int vectors = 0;
  int miscompares = 0;

  uart_transmitter #(.CYCLES_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .nRst      (nRst),
    .enable    (enable),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .tx        (tx),
    .busy      (busy),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string nm, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Line model: the queue holds the tx level for each upcoming cycle of the frame.
  bit   mq[$];
  logic exp_done = 1'b0;

  task automatic load_frame(input logic [7:0] b);
    bit bits[11];
    bits[0] = 1'b0;
    for (int k = 0; k < 8; k++) bits[k+1] = b[k];
    bits[9]  = ^b;
    bits[10] = 1'b1;
    for (int s = 0; s < 11; s++)
      for (int c = 0; c < CPB; c++) mq.push_back(bits[s]);
  endtask

  always @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      mq.delete();
      exp_done = 1'b0;
    end else if (!enable) begin
      mq.delete();
      exp_done = 1'b0;
    end else begin
      exp_done = 1'b0;
      if (mq.size() != 0) begin
        void'(mq.pop_front());
        if (mq.size() == 0) exp_done = 1'b1;
      end else if (data_valid) begin
        load_frame(data_in);
      end
    end
  end

  always @(negedge clk) begin
    chk1("tx", tx, (mq.size() != 0) ? logic'(mq[0]) : 1'b1);
    chk1("busy", busy, mq.size() != 0);
    chk1("tx_done", tx_done, exp_done);
    chk1("data_ready", data_ready, nRst && enable && (mq.size() == 0));
  end

  // Trace capture: index j is the j-th falling edge after the accepting edge.
  logic tr_tx [1:100];
  logic tr_done [1:100];
  logic tr_rdy [1:100];

  task automatic run_trace(input int n, input int drop_at, input logic [7:0] next_byte);
    @(posedge clk);
    for (int j = 1; j <= n; j++) begin
      @(negedge clk);
      tr_tx[j]   = tx;
      tr_done[j] = tx_done;
      tr_rdy[j]  = data_ready;
      if (j == 1) data_in = next_byte;
      if (j == drop_at) data_valid = 1'b0;
    end
  endtask

  function automatic logic [7:0] decode(input int base);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) b[k] = tr_tx[base + CPB*(k+1) + 2];
    return b;
  endfunction

  function automatic logic [7:0] first_done(input int lo, input int hi);
    for (int j = lo; j <= hi; j++) if (tr_done[j] === 1'b1) return 8'(j);
    return 8'd0;
  endfunction

  int pulses;

  initial begin
    nRst = 1'b0; enable = 1'b1; data_valid = 1'b0; data_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_tx", tx, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ready", data_ready, 1'b0);
    chk1("rst_done", tx_done, 1'b0);
    nRst = 1'b1;
    #1 chk1("post_rst_ready", data_ready, 1'b1);
    @(posedge clk); #2;

    // 0xA5: data 1,0,1,0,0,1,0,1, parity 0
    data_in = 8'hA5; data_valid = 1'b1;
    run_trace(46, 1, 8'h00);
    chk1("a5_start", tr_tx[2], 1'b0);
    chk8("a5_data", decode(0), 8'hA5);
    chk1("a5_parity", tr_tx[38], 1'b0);
    chk1("a5_stop", tr_tx[42], 1'b1);
    chk8("a5_done_at", first_done(1, 46), 8'd45);

    // 0x07: odd popcount, parity 1
    data_in = 8'h07; data_valid = 1'b1;
    run_trace(46, 1, 8'h00);
    chk8("07_data", decode(0), 8'h07);
    chk1("07_parity", tr_tx[38], 1'b1);
    chk8("07_done_at", first_done(1, 46), 8'd45);

    // 0x55 then 0xAA with valid held: second start right after the done cycle
    data_in = 8'h55; data_valid = 1'b1;
    run_trace(95, 46, 8'hAA);
    chk8("b2b_first", decode(0), 8'h55);
    chk1("b2b_done", tr_done[45], 1'b1);
    chk1("b2b_ready", tr_rdy[45], 1'b1);
    chk1("b2b_start2", tr_tx[46], 1'b0);
    chk8("b2b_second", decode(45), 8'hAA);
    chk8("b2b_done2_at", first_done(46, 95), 8'd90);

    // enable drop in the middle of data bit 3
    @(posedge clk); #2;
    data_in = 8'h96; data_valid = 1'b1;
    @(posedge clk); #2 data_valid = 1'b0;
    repeat (16) @(posedge clk);
    #2 enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk1("abort_tx", tx, 1'b1);
    chk1("abort_busy", busy, 1'b0);
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_done === 1'b1) pulses++;
    end
    chk8("abort_no_done", 8'(pulses), 8'd0);
    @(posedge clk); #2;
    enable = 1'b1; data_in = 8'h3C; data_valid = 1'b1;
    run_trace(46, 1, 8'h00);
    chk8("after_abort_data", decode(0), 8'h3C);
    chk8("after_abort_done_at", first_done(1, 46), 8'd45);

    // async reset during the parity bit
    @(posedge clk); #2;
    data_in = 8'hE1; data_valid = 1'b1;
    @(posedge clk); #2 data_valid = 1'b0;
    repeat (36) @(posedge clk);
    #2 nRst = 1'b0;
    #1;
    chk1("midrst_tx", tx, 1'b1);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_ready", data_ready, 1'b0);
    repeat (2) @(posedge clk);
    #2 nRst = 1'b1;
    #1;
    chk1("rel_tx", tx, 1'b1);
    chk1("rel_ready", data_ready, 1'b1);

    // randomized traffic, checked every cycle by the line model
    repeat (1500) begin
      @(posedge clk); #2;
      enable     = ($urandom_range(0, 299) != 0);
      data_valid = ($urandom_range(0, 3) != 0);
      data_in    = 8'($urandom_range(0, 255));
    end
    @(posedge clk); #2 data_valid = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
